// File: rtl/reg32_wr_arbiter.sv
// Two-requester round-robin write arbiter for a bank of 32-bit registers.
// Optional REG32_ARB_CONFLICT_CNT_EN adds a saturating both-valid conflict counter.
module reg32_wr_arbiter #(
  parameter int NREGS    = 8,
  parameter int AW       = 3,
  parameter int ZERO_REG = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0_valid,
  input  logic [AW-1:0]    req0_addr,
  input  logic [31:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [AW-1:0]    req1_addr,
  input  logic [31:0]      req1_data,
  output logic             req1_ready,
  output logic [NREGS-1:0] wr_en,
  output logic [31:0]      wr_data,
`ifdef REG32_ARB_CONFLICT_CNT_EN
  output logic [15:0]      conflict_cnt,
`endif
  output logic             last_gnt
);

  logic             gnt0_p0;
  logic             gnt1_p0;
  logic             vld_p0;
  logic [AW-1:0]    addr_p0;
  logic [31:0]      data_p0;
  logic [NREGS-1:0] en_p0;

  logic [NREGS-1:0] wr_en_p1;
  logic [31:0]      wr_data_p1;
  logic             last_gnt_p1;

  function automatic logic [NREGS-1:0] addr_decode(input logic [AW-1:0] addr);
    logic [NREGS-1:0] one;
    one = {{(NREGS-1){1'b0}}, 1'b1};
    if (ZERO_REG != 0 && addr == '0) begin
      addr_decode = '0;
    end else begin
      addr_decode = one << addr;
    end
  endfunction

  // Stage p0: arbitration. On a tie the requester that did not win last time gets the grant.
  always_comb begin
    gnt0_p0 = !RST && req0_valid && (!req1_valid || last_gnt_p1);
    gnt1_p0 = !RST && req1_valid && (!req0_valid || !last_gnt_p1);
    vld_p0  = gnt0_p0 || gnt1_p0;
    addr_p0 = gnt1_p0 ? req1_addr : req0_addr;
    data_p0 = gnt1_p0 ? req1_data : req0_data;
    en_p0   = vld_p0 ? addr_decode(addr_p0) : '0;
  end

  assign req0_ready = gnt0_p0;
  assign req1_ready = gnt1_p0;

  // Stage p1: registered bank write; data holds its last value on idle cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_en_p1    <= '0;
      wr_data_p1  <= 32'h0;
      last_gnt_p1 <= 1'b1;
    end else begin
      wr_en_p1 <= en_p0;
      if (vld_p0) begin
        wr_data_p1  <= data_p0;
        last_gnt_p1 <= gnt1_p0;
      end
    end
  end

  assign wr_en    = wr_en_p1;
  assign wr_data  = wr_data_p1;
  assign last_gnt = last_gnt_p1;

`ifdef REG32_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_p1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
    sat_inc16 = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      conflict_cnt_p1 <= 16'h0;
    end else if (req0_valid && req1_valid) begin
      conflict_cnt_p1 <= sat_inc16(conflict_cnt_p1);
    end
  end

  assign conflict_cnt = conflict_cnt_p1;
`endif

endmodule
